// File: rtl/rtb_if.sv
// Command/read bus of the register-transfer bank: command fields, read port
// and the BUSY/DONE status pair.
interface rtb_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              start;
  logic [2:0]        op;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [WIDTH-1:0]  d;
  logic [ADDR_W-1:0] raddr;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;

  modport master (
    output start, op, src, dst, d, raddr,
    input  q, busy, done
  );

  modport slave (
    input  start, op, src, dst, d, raddr,
    output q, busy, done
  );
endinterface

// File: rtl/reg_transfer_bank.sv
// Bank of 2**ADDR_W registers executing LOAD/MOVE/SWAP/CLEAR commands with a
// single register write per clock edge (SWAP additionally captures TMP).
module reg_transfer_bank #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input logic  clk,
  input logic  rst_n,
  rtb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_MOVE  = 3'b010;
  localparam logic [2:0] OP_SWAP  = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;

  typedef enum logic [1:0] {IDLE = 2'd0, SWAP2 = 2'd1, CLR = 2'd2} state_t;

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  regs_r [DEPTH];
  logic [WIDTH-1:0]  tmp_r;
  logic [ADDR_W-1:0] cnt_r, cnt_s;
  logic [ADDR_W-1:0] swap_src_r, swap_src_s;
  logic              done_r, done_s;

  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [WIDTH-1:0]  wdata_s;
  logic              tmp_we_s;

  // Next-state, single write port selection and completion decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    swap_src_s = swap_src_r;
    done_s     = 1'b0;
    we_s       = 1'b0;
    waddr_s    = bus.dst;
    wdata_s    = bus.d;
    tmp_we_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_LOAD: begin
              we_s   = 1'b1;
              done_s = 1'b1;
            end
            OP_MOVE: begin
              we_s    = 1'b1;
              wdata_s = regs_r[bus.src];
              done_s  = 1'b1;
            end
            OP_SWAP: begin
              // Destination's old value parks in TMP until the second edge.
              we_s       = 1'b1;
              tmp_we_s   = 1'b1;
              wdata_s    = regs_r[bus.src];
              swap_src_s = bus.src;
              state_s    = SWAP2;
            end
            OP_CLEAR: begin
              we_s    = 1'b1;
              waddr_s = {ADDR_W{1'b0}};
              wdata_s = {WIDTH{1'b0}};
              cnt_s   = ADDR_W'(1);
              state_s = CLR;
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      SWAP2: begin
        we_s    = 1'b1;
        waddr_s = swap_src_r;
        wdata_s = tmp_r;
        done_s  = 1'b1;
        state_s = IDLE;
      end
      CLR: begin
        we_s    = 1'b1;
        waddr_s = cnt_r;
        wdata_s = {WIDTH{1'b0}};
        if (cnt_r == LAST_IDX) begin
          cnt_s   = {ADDR_W{1'b0}};
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + ADDR_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Register array, TMP, FSM state and DONE pulse with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
      tmp_r      <= {WIDTH{1'b0}};
      cnt_r      <= {ADDR_W{1'b0}};
      swap_src_r <= {ADDR_W{1'b0}};
      state_r    <= IDLE;
      done_r     <= 1'b0;
    end else begin
      if (we_s) begin
        regs_r[waddr_s] <= wdata_s;
      end
      if (tmp_we_s) begin
        tmp_r <= regs_r[bus.dst];
      end
      cnt_r      <= cnt_s;
      swap_src_r <= swap_src_s;
      state_r    <= state_s;
      done_r     <= done_s;
    end
  end

  assign bus.q    = regs_r[bus.raddr];
  assign bus.busy = (state_r != IDLE);
  assign bus.done = done_r;
endmodule

// File: tb/tb_reg_transfer_bank.sv
// Directed and random command sequences against a command-level model of the
// register bank (whole-command effects plus BUSY/DONE timing).
module tb_reg_transfer_bank;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [WIDTH-1:0] m [DEPTH];

  rtb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  reg_transfer_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < DEPTH; r++) begin
      bus.raddr = 2'(r);
      #1;
      check8($sformatf("%s_R%0d", tag, r), bus.q, m[r]);
    end
  endtask

  function automatic int cmd_edges(input logic [2:0] op);
    case (op)
      3'd3:    return 2;
      3'd4:    return DEPTH;
      default: return 1;
    endcase
  endfunction

  function automatic logic is_valid(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  task automatic model_apply(input logic [2:0] op, input logic [1:0] src,
                             input logic [1:0] dst, input logic [7:0] d);
    logic [7:0] t;
    case (op)
      3'd1: m[dst] = d;
      3'd2: m[dst] = m[src];
      3'd3: begin
        t      = m[dst];
        m[dst] = m[src];
        m[src] = t;
      end
      3'd4: for (int r = 0; r < DEPTH; r++) m[r] = 8'h00;
      default: t = 8'h00;
    endcase
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [1:0] src,
                         input logic [1:0] dst, input logic [7:0] d);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src   = src;
    bus.dst   = dst;
    bus.d     = d;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < cmd_edges(op); k++) begin
      check1({tag, "_busy_mid"}, bus.busy, 1'b1);
      check1({tag, "_done_mid"}, bus.done, 1'b0);
      tick();
    end
    check1({tag, "_busy_end"}, bus.busy, 1'b0);
    check1({tag, "_done"}, bus.done, is_valid(op));
    model_apply(op, src, dst, d);
    check_regs(tag);
    tick();
    check1({tag, "_done_drop"}, bus.done, 1'b0);
  endtask

  initial begin
    logic [2:0] op;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.src   = 2'd0;
    bus.dst   = 2'd0;
    bus.d     = 8'h00;
    bus.raddr = 2'd0;
    for (int r = 0; r < DEPTH; r++) m[r] = 8'h00;

    // Reset for two edges while a LOAD is presented: reset must win.
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.dst   = 2'd1;
    bus.d     = 8'h5A;
    tick();
    tick();
    bus.start = 1'b0;
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_done", bus.done, 1'b0);
    check_regs("rst");
    rst_n = 1'b1;
    tick();
    check1("rst_done2", bus.done, 1'b0);

    run_cmd("load_a5", 3'd1, 2'd0, 2'd2, 8'hA5);
    run_cmd("move_2_0", 3'd2, 2'd2, 2'd0, 8'h00);
    run_cmd("load_3c", 3'd1, 2'd0, 2'd1, 8'h3C);

    // SWAP with a LOAD attempted while BUSY: the LOAD must be dropped.
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.src   = 2'd1;
    bus.dst   = 2'd2;
    tick();
    check1("swap_busy", bus.busy, 1'b1);
    check1("swap_done_mid", bus.done, 1'b0);
    bus.op  = 3'd1;
    bus.dst = 2'd3;
    bus.d   = 8'hFF;
    tick();
    bus.start = 1'b0;
    check1("swap_busy_end", bus.busy, 1'b0);
    check1("swap_done", bus.done, 1'b1);
    model_apply(3'd3, 2'd1, 2'd2, 8'h00);
    check_regs("swap");
    tick();
    check1("swap_done_drop", bus.done, 1'b0);
    check1("swap_load_ignored_busy", bus.busy, 1'b0);

    run_cmd("swap_same", 3'd3, 2'd0, 2'd0, 8'h00);
    run_cmd("nop5", 3'd5, 2'd1, 2'd3, 8'h77);
    run_cmd("nop0", 3'd0, 2'd1, 2'd3, 8'h77);
    run_cmd("load_r3", 3'd1, 2'd0, 2'd3, 8'h77);
    run_cmd("clear", 3'd4, 2'd0, 2'd0, 8'h00);

    // Reset between the two SWAP edges: abort, no DONE.
    run_cmd("pre_load1", 3'd1, 2'd0, 2'd1, 8'h11);
    run_cmd("pre_load2", 3'd1, 2'd0, 2'd2, 8'h22);
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.src   = 2'd1;
    bus.dst   = 2'd2;
    tick();
    bus.start = 1'b0;
    check1("abort_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < DEPTH; r++) m[r] = 8'h00;
    check1("abort_busy_end", bus.busy, 1'b0);
    check1("abort_done", bus.done, 1'b0);
    check_regs("abort");
    tick();
    check1("abort_done2", bus.done, 1'b0);
    run_cmd("post_abort_load", 3'd1, 2'd0, 2'd3, 8'h5A);

    // Back-to-back LOAD/MOVE keeps DONE high every cycle.
    for (int i = 0; i < 8; i++) begin
      bus.start = 1'b1;
      bus.op    = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd2;
      bus.src   = 2'($urandom_range(0, 3));
      bus.dst   = 2'($urandom_range(0, 3));
      bus.d     = 8'($urandom_range(0, 255));
      tick();
      check1("b2b_done", bus.done, 1'b1);
      check1("b2b_busy", bus.busy, 1'b0);
      model_apply(bus.op, bus.src, bus.dst, bus.d);
      check_regs("b2b");
    end
    bus.start = 1'b0;
    tick();
    check1("b2b_done_drop", bus.done, 1'b0);

    // Random command stream; CLEAR made rare so data survives.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd4 && $urandom_range(0, 3) != 0) op = 3'd1;
      run_cmd($sformatf("rnd%0d_op%0d", i, op), op, 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
